// File: rtl/qdma_h2c_pkg.sv
// rtl/qdma_h2c_pkg.sv - shared types and helpers for the QDMA H2C stream adapter
package qdma_h2c_pkg;

   localparam int DATA_W          = 512;
   localparam int KEEP_W          = DATA_W / 8;
   localparam int MAX_PKT_LEN_DEF = 9600;

   typedef enum logic [1:0] {
      FIRST,
      PASS,
      DROP
   } h2c_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] tdata;
      logic [KEEP_W-1:0] tkeep;
      logic              tlast;
      logic [15:0]       size;
      logic [15:0]       src;
      logic              err;
   } axis_pkt_beat_t;

   // Low-order bytes are valid; mty counts the empty bytes at the top of the beat.
   function automatic logic [KEEP_W-1:0] mty_to_keep(input logic [5:0] mty);
      return {KEEP_W{1'b1}} >> mty;
   endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// rtl/axis_skid_buf.sv - 2-entry register slice with registered valid/data and registered ready
module axis_skid_buf
   import qdma_h2c_pkg::*;
#(
   parameter type beat_t = axis_pkt_beat_t
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  in_valid_i,
   output logic  in_ready_o,
   input  beat_t in_data_i,
   output logic  out_valid_o,
   input  logic  out_ready_i,
   output beat_t out_data_o
);

   logic  out_valid_q, out_valid_d;
   logic  skid_valid_q, skid_valid_d;
   beat_t out_data_q, out_data_d;
   beat_t skid_data_q, skid_data_d;
   logic  push, pop;

   // Ready only reflects the skid slot, so it never sees out_ready_i combinationally.
   assign in_ready_o  = ~skid_valid_q;
   assign push        = in_valid_i & ~skid_valid_q;
   assign pop         = out_valid_q & out_ready_i;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!out_valid_q || pop) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = push;
            if (push) out_data_d = in_data_i;
         end
      end else if (push) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         out_data_q   <= '0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         out_data_q   <= out_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/qdma_h2c_adapter.sv
// rtl/qdma_h2c_adapter.sv - QDMA H2C stream to internal packet stream with size/qid checks
module qdma_h2c_adapter
   import qdma_h2c_pkg::*;
#(
   parameter int MAX_PKT_LEN = MAX_PKT_LEN_DEF,
   parameter int CNT_W       = 32
) (
   input  logic              axi_aclk,
   input  logic              axi_areset,
   input  logic              s_axis_h2c_tvalid,
   output logic              s_axis_h2c_tready,
   input  logic [DATA_W-1:0] s_axis_h2c_tdata,
   input  logic              s_axis_h2c_tlast,
   input  logic [10:0]       s_axis_h2c_tuser_qid,
   input  logic [5:0]        s_axis_h2c_tuser_mty,
   input  logic [31:0]       s_axis_h2c_tuser_mdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic [KEEP_W-1:0] m_axis_tkeep,
   output logic              m_axis_tlast,
   output logic [15:0]       m_axis_tuser_size,
   output logic [15:0]       m_axis_tuser_src,
   output logic              m_axis_tuser_err,
   output logic [CNT_W-1:0]  stat_pkt_cnt,
   output logic [CNT_W-1:0]  stat_drop_cnt,
   output logic [CNT_W-1:0]  stat_err_cnt
);

   localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);

   h2c_state_t     state_q, state_d;
   logic [15:0]    size_q;
   logic [10:0]    qid_q;
   logic [16:0]    bcnt_q;
   logic           qerr_q;
   logic [CNT_W-1:0] pkt_cnt_q, drop_cnt_q, err_cnt_q;

   logic           buf_ready, acc, first, bad, fwd, err;
   logic [15:0]    size_in, cur_size;
   logic [10:0]    cur_qid;
   logic [6:0]     beat_bytes;
   logic [17:0]    sum;
   logic [16:0]    cnt_nx;
   logic           qerr_nx;
   logic [15:0]    unused_mdata;
   axis_pkt_beat_t in_beat, out_beat;

   assign unused_mdata = s_axis_h2c_tuser_mdata[31:16];
   assign size_in      = s_axis_h2c_tuser_mdata[15:0];
   assign first        = (state_q == FIRST);
   assign acc          = s_axis_h2c_tvalid & s_axis_h2c_tready;
   assign bad          = (size_in == 16'd0) || (size_in > MAX_LEN);
   assign cur_size     = first ? size_in : size_q;
   assign cur_qid      = first ? s_axis_h2c_tuser_qid : qid_q;

   // Running byte count includes the current beat so a single-beat packet is judged in its own cycle.
   assign beat_bytes = s_axis_h2c_tlast ? (7'(KEEP_W) - {1'b0, s_axis_h2c_tuser_mty}) : 7'(KEEP_W);
   assign sum        = {1'b0, (first ? 17'd0 : bcnt_q)} + 18'(beat_bytes);
   assign cnt_nx     = sum[17] ? 17'h1FFFF : sum[16:0];
   assign qerr_nx    = (first ? 1'b0 : qerr_q) | (s_axis_h2c_tuser_qid != cur_qid);
   assign err        = (cnt_nx != {1'b0, cur_size}) | qerr_nx;
   assign fwd        = acc & ((state_q == PASS) | (first & ~bad));

   always_comb begin
      in_beat       = '0;
      in_beat.tdata = s_axis_h2c_tdata;
      in_beat.tkeep = s_axis_h2c_tlast ? mty_to_keep(s_axis_h2c_tuser_mty) : {KEEP_W{1'b1}};
      in_beat.tlast = s_axis_h2c_tlast;
      in_beat.size  = cur_size;
      in_beat.src   = {5'b0, cur_qid};
      in_beat.err   = s_axis_h2c_tlast & err;
   end

   always_comb begin
      state_d           = state_q;
      s_axis_h2c_tready = 1'b0;
      if (!axi_areset) s_axis_h2c_tready = (state_q == DROP) ? 1'b1 : buf_ready;
      unique case (state_q)
         FIRST:   if (acc && !s_axis_h2c_tlast) state_d = bad ? DROP : PASS;
         PASS:    if (acc && s_axis_h2c_tlast) state_d = FIRST;
         DROP:    if (acc && s_axis_h2c_tlast) state_d = FIRST;
         default: state_d = FIRST;
      endcase
   end

   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state_q    <= FIRST;
         size_q     <= '0;
         qid_q      <= '0;
         bcnt_q     <= '0;
         qerr_q     <= 1'b0;
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         if (acc) begin
            size_q <= cur_size;
            qid_q  <= cur_qid;
            bcnt_q <= cnt_nx;
            qerr_q <= qerr_nx;
         end
         if (acc && first && bad && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + 1'b1;
         if (fwd && s_axis_h2c_tlast && !(&pkt_cnt_q)) pkt_cnt_q <= pkt_cnt_q + 1'b1;
         if (fwd && s_axis_h2c_tlast && err && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   axis_skid_buf #(
      .beat_t(axis_pkt_beat_t)
   ) u_skid (
      .clk_i      (axi_aclk),
      .rst_i      (axi_areset),
      .in_valid_i (fwd),
      .in_ready_o (buf_ready),
      .in_data_i  (in_beat),
      .out_valid_o(m_axis_tvalid),
      .out_ready_i(m_axis_tready),
      .out_data_o (out_beat)
   );

   assign m_axis_tdata      = out_beat.tdata;
   assign m_axis_tkeep      = out_beat.tkeep;
   assign m_axis_tlast      = out_beat.tlast;
   assign m_axis_tuser_size = out_beat.size;
   assign m_axis_tuser_src  = out_beat.src;
   assign m_axis_tuser_err  = out_beat.err;
   assign stat_pkt_cnt      = pkt_cnt_q;
   assign stat_drop_cnt     = drop_cnt_q;
   assign stat_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_qdma_h2c_adapter.sv
// tb/tb_qdma_h2c_adapter.sv - directed self-checking bench for qdma_h2c_adapter
module tb_qdma_h2c_adapter;
   import qdma_h2c_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
   logic [511:0] s_tdata  = '0;
   logic [10:0]  s_qid    = '0;
   logic [5:0]   s_mty    = '0;
   logic [31:0]  s_mdata  = '0;
   logic         m_tvalid, m_tready = 1'b1, m_tlast, m_err;
   logic [511:0] m_tdata;
   logic [63:0]  m_tkeep;
   logic [15:0]  m_size, m_src;
   logic [31:0]  pkt_cnt, drop_cnt, err_cnt;

   int checks   = 0;
   int failures = 0;
   axis_pkt_beat_t out_q[$];
   axis_pkt_beat_t exp_q[$];
   axis_pkt_beat_t cur, held;
   logic stalled  = 1'b0;
   logic rand_rdy = 1'b0;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   qdma_h2c_adapter dut (
      .axi_aclk              (clk),
      .axi_areset            (rst),
      .s_axis_h2c_tvalid     (s_tvalid),
      .s_axis_h2c_tready     (s_tready),
      .s_axis_h2c_tdata      (s_tdata),
      .s_axis_h2c_tlast      (s_tlast),
      .s_axis_h2c_tuser_qid  (s_qid),
      .s_axis_h2c_tuser_mty  (s_mty),
      .s_axis_h2c_tuser_mdata(s_mdata),
      .m_axis_tvalid         (m_tvalid),
      .m_axis_tready         (m_tready),
      .m_axis_tdata          (m_tdata),
      .m_axis_tkeep          (m_tkeep),
      .m_axis_tlast          (m_tlast),
      .m_axis_tuser_size     (m_size),
      .m_axis_tuser_src      (m_src),
      .m_axis_tuser_err      (m_err),
      .stat_pkt_cnt          (pkt_cnt),
      .stat_drop_cnt         (drop_cnt),
      .stat_err_cnt          (err_cnt)
   );

   task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic axis_pkt_beat_t mk(input logic [511:0] d, input logic [63:0] k, input logic l,
                                         input logic [15:0] sz, input logic [15:0] src, input logic e);
      axis_pkt_beat_t r;
      r.tdata = d; r.tkeep = k; r.tlast = l; r.size = sz; r.src = src; r.err = e;
      return r;
   endfunction

   // Output monitor: records accepted beats and checks stability across stalls.
   always @(negedge clk) begin
      cur = mk(m_tdata, m_tkeep, m_tlast, m_size, m_src, m_err);
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            checks++;
            assert (m_tvalid === 1'b1 && cur === held) else begin
               failures++;
               $error("FAIL stall_stable observed=%0h expected=%0h", 640'(cur), 640'(held));
            end
         end
         if (m_tvalid && m_tready) out_q.push_back(cur);
         stalled = m_tvalid & ~m_tready;
         held    = cur;
      end
   end

   always @(posedge clk) if (rand_rdy) begin
      #1 m_tready = 1'($urandom_range(0, 1));
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [511:0] d, input logic l, input logic [10:0] q,
                            input logic [5:0] mty, input logic [15:0] sz);
      int n = 0;
      s_tdata = d; s_tlast = l; s_qid = q; s_mty = mty; s_mdata = {16'hBEEF, sz};
      s_tvalid = 1'b1;
      @(negedge clk);
      while (s_tready !== 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $error("FAIL send_timeout observed=stalled expected=ready");
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
   endtask

   task automatic expect_beat(input string tag, input axis_pkt_beat_t exp);
      axis_pkt_beat_t b;
      chk({tag, "_present"}, 640'(out_q.size() != 0), 640'(1));
      if (out_q.size() != 0) begin
         b = out_q.pop_front();
         chk(tag, 640'(b), 640'(exp));
      end
   endtask

   initial begin
      logic [511:0] d;
      int n, nbad;

      // Reset state
      idle(3);
      chk("rst_tvalid", 640'(m_tvalid), 640'(0));
      chk("rst_tready", 640'(s_tready), 640'(0));
      chk("rst_outs", 640'({m_tdata, m_tkeep, m_tlast, m_size, m_src, m_err}), 640'(0));
      chk("rst_cnts", 640'({pkt_cnt, drop_cnt, err_cnt}), 640'(0));
      rst = 1'b0;
      idle(1);
      chk("post_rst_tready", 640'(s_tready), 640'(1));

      // 100-byte packet, 2 beats; mty on the first beat must be ignored
      chk("t1_idle_valid", 640'(m_tvalid), 640'(0));
      send_beat({16{32'hA1A1_0001}}, 1'b0, 11'd3, 6'd63, 16'd100);
      chk("t1_latency", 640'(m_tvalid), 640'(1));
      send_beat({16{32'hA1A1_0002}}, 1'b1, 11'd3, 6'd28, 16'd100);
      idle(3);
      expect_beat("t1_beat0", mk({16{32'hA1A1_0001}}, ONES, 1'b0, 16'd100, 16'd3, 1'b0));
      expect_beat("t1_beat1", mk({16{32'hA1A1_0002}}, 64'h0000_000F_FFFF_FFFF, 1'b1, 16'd100, 16'd3, 1'b0));
      chk("t1_pkt_cnt", 640'(pkt_cnt), 640'(1));

      // Size 0 and size 9601 dropped, then a good 64-byte packet
      send_beat({16{32'hDEAD_0000}}, 1'b1, 11'd1, 6'd0, 16'd0);
      send_beat({16{32'hDEAD_9601}}, 1'b1, 11'd1, 6'd0, 16'd9601);
      send_beat({16{32'hC0DE_0040}}, 1'b1, 11'd7, 6'd0, 16'd64);
      idle(3);
      expect_beat("t2_good", mk({16{32'hC0DE_0040}}, ONES, 1'b1, 16'd64, 16'd7, 1'b0));
      chk("t2_only_one", 640'(out_q.size()), 640'(0));
      chk("t2_drop_cnt", 640'(drop_cnt), 640'(2));
      chk("t2_pkt_cnt", 640'(pkt_cnt), 640'(2));

      // Declared 128 bytes, 192 sent
      send_beat({16{32'hB0B0_0001}}, 1'b0, 11'd2, 6'd0, 16'd128);
      send_beat({16{32'hB0B0_0002}}, 1'b0, 11'd2, 6'd0, 16'd128);
      send_beat({16{32'hB0B0_0003}}, 1'b1, 11'd2, 6'd0, 16'd128);
      idle(3);
      expect_beat("t3_beat0", mk({16{32'hB0B0_0001}}, ONES, 1'b0, 16'd128, 16'd2, 1'b0));
      expect_beat("t3_beat1", mk({16{32'hB0B0_0002}}, ONES, 1'b0, 16'd128, 16'd2, 1'b0));
      expect_beat("t3_beat2", mk({16{32'hB0B0_0003}}, ONES, 1'b1, 16'd128, 16'd2, 1'b1));
      chk("t3_err_cnt", 640'(err_cnt), 640'(1));

      // qid changes 5 -> 6 mid-packet
      send_beat({16{32'h5555_0001}}, 1'b0, 11'd5, 6'd0, 16'd128);
      send_beat({16{32'h6666_0002}}, 1'b1, 11'd6, 6'd0, 16'd128);
      idle(3);
      expect_beat("t4_beat0", mk({16{32'h5555_0001}}, ONES, 1'b0, 16'd128, 16'd5, 1'b0));
      expect_beat("t4_beat1", mk({16{32'h6666_0002}}, ONES, 1'b1, 16'd128, 16'd5, 1'b1));
      chk("t4_err_cnt", 640'(err_cnt), 640'(2));

      // Declared size exactly MAX_PKT_LEN is forwarded (short, so flagged)
      send_beat({16{32'h2580_0001}}, 1'b1, 11'd9, 6'd0, 16'd9600);
      idle(3);
      expect_beat("t_max_len", mk({16{32'h2580_0001}}, ONES, 1'b1, 16'd9600, 16'd9, 1'b1));
      chk("t_max_cnts", 640'({pkt_cnt, drop_cnt, err_cnt}), 640'({32'd5, 32'd2, 32'd3}));

      // 1000 back-to-back single-beat packets under random backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         d = {16{32'(i) ^ 32'h5A5A_0000}};
         exp_q.push_back(mk(d, ONES, 1'b1, 16'd64, {5'b0, 11'(i)}, 1'b0));
         send_beat(d, 1'b1, 11'(i), 6'd0, 16'd64);
      end
      n = 0;
      while (out_q.size() < 1000 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2 m_tready = 1'b1;
      idle(3);
      chk("t5_count", 640'(out_q.size()), 640'(1000));
      nbad = 0;
      for (int i = 0; i < 1000 && i < out_q.size(); i++)
         if (out_q[i] !== exp_q[i]) nbad++;
      chk("t5_data", 640'(nbad), 640'(0));
      chk("t5_pkt_cnt", 640'(pkt_cnt), 640'(1005));
      out_q.delete();

      // Reset mid-packet after beat 1 of 3
      send_beat({16{32'h7777_0001}}, 1'b0, 11'd9, 6'd0, 16'd192);
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", 640'(m_tvalid), 640'(0));
      chk("t6_rst_data", 640'(m_tdata), 640'(0));
      chk("t6_rst_tready", 640'(s_tready), 640'(0));
      chk("t6_rst_cnts", 640'({pkt_cnt, drop_cnt, err_cnt}), 640'(0));
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      out_q.delete();
      send_beat({16{32'h4444_0001}}, 1'b1, 11'd4, 6'd0, 16'd64);
      idle(3);
      expect_beat("t6_after", mk({16{32'h4444_0001}}, ONES, 1'b1, 16'd64, 16'd4, 1'b0));
      chk("t6_cnts", 640'({pkt_cnt, drop_cnt, err_cnt}), 640'({32'd1, 32'd0, 32'd0}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
